// File: rtl/pal_cfg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : pal_cfg_pkg                                                 |
// | Description: Shared types, constants and sizing helper for the PAL       |
// |              configuration loader.                                       |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package pal_cfg_pkg;

  // Loader state type and its encodings
  typedef logic [2:0] pal_state_t;

  localparam pal_state_t S_IDLE  = 3'd0;
  localparam pal_state_t S_LOAD  = 3'd1;
  localparam pal_state_t S_SHIFT = 3'd2;
  localparam pal_state_t S_CHECK = 3'd3;
  localparam pal_state_t S_APPLY = 3'd4;
  localparam pal_state_t S_ERR   = 3'd5;

  // CRC-8 used to protect the configuration stream
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Number of configuration bits of an N-input, M-output, P-term PAL:
  // two literal columns (true/complement) per input per term plus the OR plane.
  function automatic int cfg_bits(input int n, input int m, input int p);
    return 2 * n * p + p * m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pal_cfg_crc8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : pal_cfg_crc8                                                |
// | Description: Bit-serial CRC-8 (MSB-first register) over the shifted      |
// |              configuration bits.                                         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module pal_cfg_crc8
  import pal_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       res_n,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic fb;

  assign fb = crc[7] ^ bit_in;

  // Shift one bit into the CRC register per valid bit; clear restarts the sum
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      crc <= CRC8_INIT;
    end else if (clear) begin
      crc <= CRC8_INIT;
    end else if (bit_valid) begin
      crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pal_cfg_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : pal_cfg_loader                                              |
// | Description: Accepts config bytes over valid/ready, serialises them      |
// |              LSB-first onto the PAL cfg line with a shift strobe per bit,|
// |              then enables the PAL after exactly CFG_BITS bits.           |
// |              Optional macro PAL_CFG_CRC_EN adds a CRC-8 check byte.      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module pal_cfg_loader
  import pal_cfg_pkg::*;
#(
  parameter  int N        = 8,
  parameter  int M        = 6,
  parameter  int P        = 19,
  localparam int CFG_BITS = cfg_bits(N, M, P),
  localparam int CW       = $clog2(CFG_BITS + 1)
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          start_i,
  input  logic [7:0]    in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic          cfg_o,
  output logic          cfg_shift_o,
  output logic          cfg_en_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [CW-1:0] bit_cnt_o
);

  localparam logic [CW-1:0] CFG_LAST = CW'(CFG_BITS);

  pal_state_t    state;
  pal_state_t    state_nxt;
  logic [6:0]    sh_data;     // bits of the current byte still to go out
  logic [2:0]    sh_left;     // strobes remaining after the current one
  logic [2:0]    left_init;
  logic [CW-1:0] bits_left;
  logic          load_hs;
  logic          shift_more;
  logic          check_pass;

  // start_i always wins over a handshake in the same cycle
  assign in_ready_o = ((state == S_LOAD) | (state == S_CHECK)) & ~start_i;
  assign load_hs    = (state == S_LOAD) & in_valid_i & ~start_i;
  assign shift_more = (state == S_SHIFT) & (sh_left != 3'd0);

  // Last byte only carries the residual bits; the rest are discarded
  assign bits_left = CFG_LAST - bit_cnt_o;
  assign left_init = (bits_left >= CW'(8)) ? 3'd7 : (bits_left[2:0] - 3'd1);

`ifdef PAL_CFG_CRC_EN
  logic [7:0] crc;
  localparam pal_state_t S_BITS_DONE = S_CHECK;

  pal_cfg_crc8 u_crc (
    .clk       (clk),
    .res_n     (res_n),
    .clear     (start_i),
    .bit_valid (cfg_shift_o),
    .bit_in    (cfg_o),
    .crc       (crc)
  );

  assign check_pass = (in_data_i == crc);
`else
  localparam pal_state_t S_BITS_DONE = S_APPLY;
  assign check_pass = 1'b0;
`endif

  // Next-state decode
  always_comb begin
    state_nxt = state;
    if (start_i) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_LOAD:  if (in_valid_i) state_nxt = S_SHIFT;
        S_SHIFT: if (sh_left == 3'd0)
                   state_nxt = (bit_cnt_o == CFG_LAST) ? S_BITS_DONE : S_LOAD;
        S_CHECK: if (in_valid_i) state_nxt = check_pass ? S_APPLY : S_ERR;
        default: state_nxt = state;
      endcase
    end
  end

  // State register and registered status flags decoded from the next state
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= S_IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      cfg_en_o <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy_o   <= (state_nxt == S_LOAD) | (state_nxt == S_SHIFT) | (state_nxt == S_CHECK);
      done_o   <= (state_nxt == S_APPLY);
      cfg_en_o <= (state_nxt == S_APPLY);
    end
  end

`ifdef PAL_CFG_CRC_EN
  // Error flag held while the CRC mismatch state persists
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      err_o <= 1'b0;
    end else begin
      err_o <= (state_nxt == S_ERR);
    end
  end
`else
  assign err_o = 1'b0;
`endif

  // Serialiser: first bit goes out the cycle after the handshake, one per cycle
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cfg_o       <= 1'b0;
      cfg_shift_o <= 1'b0;
      sh_data     <= 7'd0;
      sh_left     <= 3'd0;
      bit_cnt_o   <= '0;
    end else if (start_i) begin
      cfg_shift_o <= 1'b0;
      sh_left     <= 3'd0;
      bit_cnt_o   <= '0;
    end else if (load_hs) begin
      cfg_o       <= in_data_i[0];
      sh_data     <= in_data_i[7:1];
      sh_left     <= left_init;
      cfg_shift_o <= 1'b1;
      bit_cnt_o   <= bit_cnt_o + CW'(1);
    end else if (shift_more) begin
      cfg_o       <= sh_data[0];
      sh_data     <= {1'b0, sh_data[6:1]};
      sh_left     <= sh_left - 3'd1;
      cfg_shift_o <= 1'b1;
      bit_cnt_o   <= bit_cnt_o + CW'(1);
    end else begin
      cfg_shift_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pal_cfg_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_pal_cfg_loader                                           |
// | Description: Self-checking bench for pal_cfg_loader with a behavioural   |
// |              bit-stream model. Build with PAL_CFG_CRC_EN for CRC tests.  |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pal_cfg_loader;

  localparam int CFG = 418;  // 2*8*19 + 19*6
`ifdef PAL_CFG_CRC_EN
  localparam bit HAS_CRC = 1'b1;
`else
  localparam bit HAS_CRC = 1'b0;
`endif

  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_SHIFT = 2, PH_CHECK = 3, PH_APPLY = 4, PH_ERR = 5;

  logic       clk = 1'b0;
  logic       res_n = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] in_data_i = 8'h00;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o, cfg_o, cfg_shift_o, cfg_en_o, busy_o, done_o, err_o;
  logic [8:0] bit_cnt_o;

  pal_cfg_loader dut (
    .clk         (clk),
    .res_n       (res_n),
    .start_i     (start_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .cfg_o       (cfg_o),
    .cfg_shift_o (cfg_shift_o),
    .cfg_en_o    (cfg_en_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .bit_cnt_o   (bit_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: accepted bytes become a queue of pending bits, one
  // leaves per cycle; load ends when CFG bits have been sent.
  int         m_phase = PH_IDLE;
  int         m_cnt   = 0;
  int         m_k;
  bit         m_q[$];
  bit         m_shift = 1'b0;
  bit         m_cfg   = 1'b0;
  bit         m_fb;
  logic [7:0] m_crc   = 8'h00;

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      m_phase = PH_IDLE; m_cnt = 0; m_q.delete(); m_shift = 0; m_cfg = 0; m_crc = 8'h00;
    end else if (start_i) begin
      m_phase = PH_LOAD; m_cnt = 0; m_q.delete(); m_shift = 0; m_crc = 8'h00;
    end else begin
      if (m_phase == PH_LOAD && in_valid_i) begin
        m_k = CFG - m_cnt;
        if (m_k > 8) m_k = 8;
        for (int b = 0; b < m_k; b++) m_q.push_back(in_data_i[b]);
        m_phase = PH_SHIFT;
      end else if (m_phase == PH_CHECK && in_valid_i) begin
        m_phase = (in_data_i == m_crc) ? PH_APPLY : PH_ERR;
      end
      if (m_phase == PH_SHIFT) begin
        if (m_q.size() > 0) begin
          m_cfg   = m_q.pop_front();
          m_shift = 1'b1;
          m_cnt++;
          m_fb    = m_crc[7] ^ m_cfg;
          m_crc   = {m_crc[6:0], 1'b0} ^ (m_fb ? 8'h07 : 8'h00);
        end else begin
          m_shift = 1'b0;
          m_phase = (m_cnt == CFG) ? (HAS_CRC ? PH_CHECK : PH_APPLY) : PH_LOAD;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("in_ready", int'(in_ready_o), int'((m_phase == PH_LOAD || m_phase == PH_CHECK) && !start_i));
    chk("cfg_shift", int'(cfg_shift_o), int'(m_shift));
    chk("cfg", int'(cfg_o), int'(m_cfg));
    chk("bit_cnt", int'(bit_cnt_o), m_cnt);
    chk("busy", int'(busy_o), int'(m_phase == PH_LOAD || m_phase == PH_SHIFT || m_phase == PH_CHECK));
    chk("done", int'(done_o), int'(m_phase == PH_APPLY));
    chk("cfg_en", int'(cfg_en_o), int'(m_phase == PH_APPLY));
    chk("err", int'(err_o), int'(m_phase == PH_ERR));
  end

  // Strobe monitor for the literal end-of-test pins
  int         strobe_cnt = 0;
  logic [7:0] first_bits = 8'h00;
  always @(negedge clk) begin
    if (cfg_shift_o) begin
      if (strobe_cnt < 8) first_bits[strobe_cnt] = cfg_o;
      strobe_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Offer n bytes base+i*step; valid asserted pct% of cycles
  task automatic feed(input int n, input logic [7:0] base, input logic [7:0] step, input int pct);
    int   i = 0;
    int   guard = 0;
    logic acc;
    while (i < n) begin
      in_data_i  = base + 8'(i) * step;
      in_valid_i = ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0;
      @(negedge clk);
      acc = in_valid_i & in_ready_o;
      tick();
      if (acc) i++;
      guard++;
      if (guard > 4000) begin
        n_checks++; n_fail++;
        $display("FAIL feed_timeout: got %0d bytes accepted, expected %0d", i, n);
        break;
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int w = 0;
    while (!done_o && w < 40) begin
      tick();
      w++;
    end
    chk(name, int'(done_o), 1);
  endtask

  int taken;

  initial begin
    // 1: reset with inputs toggling
    #1 res_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      start_i    = 1'($urandom_range(0, 1));
      in_valid_i = 1'($urandom_range(0, 1));
      in_data_i  = 8'($urandom_range(0, 255));
      tick();
      chk("rst_ready", int'(in_ready_o), 0);
      chk("rst_shift", int'(cfg_shift_o), 0);
      chk("rst_en", int'(cfg_en_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_cnt", int'(bit_cnt_o), 0);
    end
    start_i = 1'b0; in_valid_i = 1'b0;
    res_n = 1'b1;
    tick();

    // 2: 53 bytes of 0xA5 back-to-back, then an extra byte offered
    pulse_start();
    strobe_cnt = 0;
    feed(53, 8'hA5, 8'h00, 100);
    in_valid_i = 1'b1;
    wait_done("t2_done");
    chk("t2_strobes", strobe_cnt, 418);
    chk("t2_first_bits", int'(first_bits), 8'hA5);
    chk("t2_bit_cnt", int'(bit_cnt_o), 418);
    chk("t2_cfg_en", int'(cfg_en_o), 1);
    taken = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (in_valid_i && in_ready_o) taken++;
      tick();
    end
    chk("t2_extra_taken", taken, 0);
    in_valid_i = 1'b0;

    // 3: handshake gaps
    pulse_start();
    strobe_cnt = 0;
    feed(53, 8'hA5, 8'h00, 30);
    wait_done("t3_done");
    chk("t3_strobes", strobe_cnt, 418);
    chk("t3_first_bits", int'(first_bits), 8'hA5);

    // 4: restart after 20 bytes, colliding with a valid byte
    pulse_start();
    feed(20, 8'h11, 8'h25, 100);
    for (int w = 0; w < 20 && !in_ready_o; w++) tick();
    chk("t4_cnt_pre", int'(bit_cnt_o), 160);
    start_i = 1'b1; in_valid_i = 1'b1; in_data_i = 8'hFF;
    #1 chk("t4_ready_blocked", int'(in_ready_o), 0);
    tick();
    start_i = 1'b0; in_valid_i = 1'b0;
    chk("t4_cnt_cleared", int'(bit_cnt_o), 0);
    chk("t4_en_low", int'(cfg_en_o), 0);
    strobe_cnt = 0;
    feed(53, 8'h3C, 8'h5B, 100);
    wait_done("t4_done");
    chk("t4_strobes", strobe_cnt, 418);
    chk("t4_first_bits", int'(first_bits), 8'h3C);

    // 5: asynchronous reset in the middle of byte 30
    pulse_start();
    feed(30, 8'h96, 8'h01, 100);
    #2 res_n = 1'b0;
    #1;
    chk("t5_shift", int'(cfg_shift_o), 0);
    chk("t5_cnt", int'(bit_cnt_o), 0);
    chk("t5_busy", int'(busy_o), 0);
    chk("t5_cfg", int'(cfg_o), 0);
    strobe_cnt = 0;
    repeat (3) tick();
    chk("t5_no_strobes", strobe_cnt, 0);
    res_n = 1'b1;
    tick();

`ifdef PAL_CFG_CRC_EN
    // 6: CRC check byte, matching then mismatching
    pulse_start();
    feed(53, 8'h00, 8'h00, 100);
    feed(1, 8'h00, 8'h00, 100);
    wait_done("t6_done_good");
    chk("t6_err_good", int'(err_o), 0);
    pulse_start();
    feed(53, 8'h00, 8'h00, 100);
    feed(1, 8'h01, 8'h00, 100);
    repeat (2) tick();
    chk("t6_err_bad", int'(err_o), 1);
    chk("t6_en_bad", int'(cfg_en_o), 0);
    pulse_start();
    chk("t6_err_cleared", int'(err_o), 0);
    chk("t6_busy_restart", int'(busy_o), 1);
`else
    chk("t6_err_tied", int'(err_o), 0);
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
